// File: rtl/regfile.sv
// ============================================================================
// regfile : 32 x DATA_W GPRs plus HI/LO, two forwarded combinational read ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    gpr_d = gpr_q;
    if (we && (waddr != '0)) begin
      gpr_d[waddr] = wdata;
    end
    // r0 is hardwired; pinning its next-state lets synthesis prune the flops
    gpr_d[0] = '0;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (whilo) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst && re1 && (raddr1 != '0)) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : gpr_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && (raddr2 != '0)) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : gpr_q[raddr2];
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst) begin
      hi_o = whilo ? hi_i : hi_q;
      lo_o = whilo ? lo_i : lo_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// tb_regfile : directed stimulus with a queue-based scoreboard for regfile
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        whilo;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endfunction

  // Monitor: outputs are combinational, so they are presented whenever an
  // expectation is queued; the stimulus holds inputs steady until it is popped.
  initial begin : monitor
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      cmp(e.name, "rdata1", rdata1, e.r1);
      cmp(e.name, "rdata2", rdata2, e.r2);
      cmp(e.name, "hi_o",   hi_o,   e.hi);
      cmp(e.name, "lo_o",   lo_o,   e.lo);
    end
  end

  task automatic expect4(input string n, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    #1;
    e.name = n;
    e.r1   = e1;
    e.r2   = e2;
    e.hi   = eh;
    e.lo   = el;
    sb.push_back(e);
    #1;
  endtask

  // Advance one rising edge; inputs change on the falling edge like writeback.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  initial begin : stimulus
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; whilo = 1'b0;
    hi_i = '0; lo_i = '0;
    rd(1'b1, 5'd5, 1'b1, 5'd5);
    @(negedge clk);
    expect4("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);

    // Load state, then pulse reset mid-cycle
    rst = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    whilo = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;
    step();
    we = 1'b0; whilo = 1'b0;
    expect4("loaded", 32'h12345678, 32'h12345678, 32'hAAAA0000, 32'h0000BBBB);
    #1;
    rst = 1'b0;
    expect4("rst_async", 32'h0, 32'h0, 32'h0, 32'h0);
    we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D;
    whilo = 1'b1; hi_i = 32'h5; lo_i = 32'h6;
    step();
    rst = 1'b1; we = 1'b0; whilo = 1'b0;
    expect4("rst_cleared", 32'h0, 32'h0, 32'h0, 32'h0);

    // Write then read
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0;
    rd(1'b1, 5'd3, 1'b0, 5'd3);
    expect4("wr_rd", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);

    // Register 0 immutable, also under forwarding
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    step();
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    expect4("r0_fwd", 32'h0, 32'h0, 32'h0, 32'h0);
    we = 1'b0;
    expect4("r0_stored", 32'h0, 32'h0, 32'h0, 32'h0);

    // Forwarding
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    step();
    waddr = 5'd8; wdata = 32'h88888888;
    step();
    waddr = 5'd7; wdata = 32'h22222222;
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    expect4("fwd_both", 32'h22222222, 32'h22222222, 32'h0, 32'h0);
    step();
    we = 1'b0;
    expect4("fwd_committed", 32'h22222222, 32'h22222222, 32'h0, 32'h0);
    we = 1'b1; waddr = 5'd7; wdata = 32'h33333333;
    rd(1'b1, 5'd7, 1'b1, 5'd8);
    expect4("fwd_port_indep", 32'h33333333, 32'h88888888, 32'h0, 32'h0);
    we = 1'b0;
    expect4("fwd_off", 32'h22222222, 32'h88888888, 32'h0, 32'h0);

    // HI/LO
    whilo = 1'b1; hi_i = 32'h00000001; lo_i = 32'hFFFFFFFE;
    expect4("hilo_fwd", 32'h22222222, 32'h88888888, 32'h00000001, 32'hFFFFFFFE);
    step();
    whilo = 1'b0; hi_i = '0; lo_i = '0;
    expect4("hilo_kept", 32'h22222222, 32'h88888888, 32'h00000001, 32'hFFFFFFFE);
    whilo = 1'b1; hi_i = 32'h00000012; lo_i = 32'h00000034;
    we = 1'b1; waddr = 5'd31; wdata = 32'h80000000;
    rd(1'b1, 5'd31, 1'b1, 5'd3);
    expect4("hilo_gpr_fwd", 32'h80000000, 32'hDEADBEEF, 32'h00000012, 32'h00000034);
    step();
    whilo = 1'b0; we = 1'b0; hi_i = '0; lo_i = '0;
    expect4("hilo_gpr_commit", 32'h80000000, 32'hDEADBEEF, 32'h00000012, 32'h00000034);

    // Full sweep
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 32'(k) * 32'h01010101;
      step();
    end
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd(1'b1, 5'(k), 1'b1, 5'(31 - k));
      expect4($sformatf("sweep_r%0d", k), 32'(k) * 32'h01010101,
              32'(31 - k) * 32'h01010101, 32'h00000012, 32'h00000034);
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
